// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Load/store codes, fault causes, FSM states, lane enables and load formatting.
package dmem_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_B    = 3'b001,
    LD_H    = 3'b010,
    LD_W    = 3'b011,
    LD_BU   = 3'b101,
    LD_HU   = 3'b110
  } load_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_B    = 2'b01,
    ST_H    = 2'b10,
    ST_W    = 2'b11
  } store_e;

  typedef enum logic [1:0] {
    F_OK  = 2'b00,
    F_MIS = 2'b01,
    F_OOR = 2'b10,
    F_ILL = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  function automatic logic [3:0] byte_en(
    input store_e     st,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b0000;
    case (st)
      ST_B:    be = 4'b0001 << off;
      ST_H:    be = 4'b0011 << off;
      ST_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_fmt(
    input load_e       ld,
    input logic [1:0]  off,
    input logic [31:0] w
  );
    logic [31:0] s;
    logic [31:0] r;
    s = w >> {off, 3'b000};
    r = '0;
    case (ld)
      LD_B:    r = {{24{s[7]}}, s[7:0]};
      LD_BU:   r = {24'd0, s[7:0]};
      LD_H:    r = {{16{s[15]}}, s[15:0]};
      LD_HU:   r = {16'd0, s[15:0]};
      LD_W:    r = w;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised SRAM bank with four byte lanes.
// Synchronous write, registered synchronous read; contents are never reset.
module dmem_bank #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// Multi-cycle RV32I data-memory load/store unit with wait states and faults.
// Requests are serialised: IDLE -> [WAIT] -> ACCESS -> RESP -> IDLE.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_load,
  input  logic [1:0]  req_store,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    ld_q;
  logic [1:0]    st_q;
  fault_e        flt_q;
  fault_e        fault_q;
  logic [31:0]   rdata_q;

  logic        accept;
  logic        ld_ok, ill, mis, oor, noop;
  fault_e      fault_in;
  logic [1:0]  off_in;
  logic        bank_en;
  logic [31:0] bank_rdata;
  logic [31:0] cur_rdata;

  assign accept = req_valid && (state_q == S_IDLE);
  assign off_in = req_addr[1:0];
  assign noop   = (req_load == 3'b000) && (req_store == 2'b00);

  always_comb begin
    ld_ok = (req_load == LD_NONE) || (req_load == LD_B) ||
            (req_load == LD_H)    || (req_load == LD_W) ||
            (req_load == LD_BU)   || (req_load == LD_HU);
    ill = ((req_load != 3'b000) && (req_store != 2'b00)) || !ld_ok;
    mis = (((req_load == LD_H) || (req_load == LD_HU) ||
            (req_store == ST_H)) && (off_in == 2'b11)) ||
          (((req_load == LD_W) || (req_store == ST_W)) &&
            (off_in != 2'b00));
    oor = |req_addr[31:AW+2];
    if (ill)      fault_in = F_ILL;
    else if (mis) fault_in = F_MIS;
    else if (oor) fault_in = F_OOR;
    else          fault_in = F_OK;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if ((fault_in != F_OK) || noop) begin
            state_d = S_RESP;
          end else if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WLOAD;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      st_q    <= '0;
      flt_q   <= F_OK;
    end else if (accept) begin
      addr_q  <= req_addr[AW+1:0];
      wdata_q <= req_wdata;
      ld_q    <= req_load;
      st_q    <= req_store;
      flt_q   <= fault_in;
    end
  end

  // Reset in ACCESS wins: the bank never sees the enable on that edge.
  assign bank_en = (state_q == S_ACCESS) && !rst;

  dmem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk   (clk),
    .en    (bank_en),
    .we    (st_q != 2'b00),
    .be    (byte_en(store_e'(st_q), addr_q[1:0])),
    .idx   (addr_q[AW+1:2]),
    .wdata (wdata_q << {addr_q[1:0], 3'b000}),
    .rdata (bank_rdata)
  );

  assign cur_rdata = ((flt_q == F_OK) && (ld_q != 3'b000)) ?
    load_fmt(load_e'(ld_q), addr_q[1:0], bank_rdata) : '0;

  // Held copies of the last response, shown outside RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      fault_q <= F_OK;
    end else if (state_q == S_RESP) begin
      rdata_q <= cur_rdata;
      fault_q <= flt_q;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = (state_q == S_RESP) ? cur_rdata : rdata_q;
  assign resp_fault = (state_q == S_RESP) ? flt_q : fault_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: one instance with no wait states,
// one with three, checked against hand-computed values.
module tb_dmem_lsu;

  logic        clk;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_load   [2];
  logic [1:0]  req_store  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic [1:0]  resp_fault [2];
  logic        busy       [2];

  int checks = 0;
  int errors = 0;

  dmem_lsu #(.DEPTH(256), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_load(req_load[0]), .req_store(req_store[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_fault(resp_fault[0]), .busy(busy[0])
  );

  dmem_lsu #(.DEPTH(256), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_load(req_load[1]), .req_store(req_store[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_fault(resp_fault[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // lat counts edges from acceptance to the edge that sees resp_valid.
  task automatic do_req(
    input  int          d,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [2:0]  ld,
    input  logic [1:0]  st,
    output logic [31:0] rd,
    output logic [1:0]  ft,
    output int          lat,
    output int          bz
  );
    int n;
    bit got;
    rd  = '0;
    ft  = '0;
    lat = -1;
    bz  = 0;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_load[d]  = ld;
    req_store[d] = st;
    n = 0;
    while (!req_ready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d addr=%h", d, a);
      req_valid[d] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      req_addr[d]  = ~a;
      req_wdata[d] = ~wd;
      req_load[d]  = 3'b111;
      req_store[d] = 2'b11;
      got = 1'b0;
      for (int i = 1; i <= 40 && !got; i++) begin
        @(negedge clk);
        if (busy[d]) bz++;
        if (resp_valid[d]) begin
          got = 1'b1;
          lat = i;
          rd  = resp_rdata[d];
          ft  = resp_fault[d];
        end
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL resp_timeout dut%0d addr=%h", d, a);
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 ||
          resp_rdata[d] !== 32'h0 || resp_fault[d] !== 2'b00 ||
          busy[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d rdy=%b rv=%b rd=%h f=%b bz=%b want 1 0 0 0 0",
          d, req_ready[d], resp_valid[d], resp_rdata[d],
          resp_fault[d], busy[d]);
      end
    end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic [1:0] ft; int lat, bz;
    do_req(0, 32'h10, 32'hDEADBEEF, 3'b000, 2'b11, rd, ft, lat, bz);
    checks++;
    if (ft !== 2'b00 || lat != 2 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sw_word f=%b lat=%0d rd=%h want 00 2 0", ft, lat, rd);
    end
    do_req(0, 32'h10, 32'h0, 3'b011, 2'b00, rd, ft, lat, bz);
    checks++;
    if (rd !== 32'hDEADBEEF || ft !== 2'b00 || lat != 2) begin
      errors++;
      $display("FAIL lw_word rd=%h f=%b lat=%0d want deadbeef 00 2",
        rd, ft, lat);
    end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic [1:0] ft; int lat, bz;
    logic [31:0] addrs [4];
    logic [2:0]  lds   [4];
    logic [31:0] exp   [4];
    addrs = '{32'h13, 32'h13, 32'h12, 32'h11};
    lds   = '{3'b001, 3'b101, 3'b010, 3'b110};
    exp   = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000ADBE};
    for (int i = 0; i < 4; i++) begin
      do_req(0, addrs[i], 32'h0, lds[i], 2'b00, rd, ft, lat, bz);
      checks++;
      if (rd !== exp[i] || ft !== 2'b00) begin
        errors++;
        $display("FAIL subword%0d rd=%h f=%b want %h 00",
          i, rd, ft, exp[i]);
      end
    end
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic [1:0] ft; int lat, bz;
    do_req(0, 32'h11, 32'hAAAA_AA55, 3'b000, 2'b01, rd, ft, lat, bz);
    do_req(0, 32'h10, 32'h0, 3'b011, 2'b00, rd, ft, lat, bz);
    checks++;
    if (rd !== 32'hDEAD55EF) begin
      errors++;
      $display("FAIL sb_merge rd=%h want dead55ef", rd);
    end
    do_req(0, 32'h12, 32'hBBBB_1234, 3'b000, 2'b10, rd, ft, lat, bz);
    do_req(0, 32'h10, 32'h0, 3'b011, 2'b00, rd, ft, lat, bz);
    checks++;
    if (rd !== 32'h123455EF) begin
      errors++;
      $display("FAIL sh_merge rd=%h want 123455ef", rd);
    end
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic [1:0] ft; int lat, bz;
    logic [31:0] fa  [6];
    logic [2:0]  fl  [6];
    logic [1:0]  fs  [6];
    logic [1:0]  fe  [6];
    fa = '{32'h12, 32'h13, 32'h400, 32'h10, 32'h10, 32'h10};
    fl = '{3'b011, 3'b000, 3'b000, 3'b011, 3'b100, 3'b000};
    fs = '{2'b00,  2'b10,  2'b11,  2'b11,  2'b00,  2'b00};
    fe = '{2'b01,  2'b01,  2'b10,  2'b11,  2'b11,  2'b00};
    do_req(0, 32'h0, 32'hA5A5A5A5, 3'b000, 2'b11, rd, ft, lat, bz);
    for (int i = 0; i < 6; i++) begin
      do_req(0, fa[i], 32'h0BAD0BAD, fl[i], fs[i], rd, ft, lat, bz);
      checks++;
      if (ft !== fe[i] || lat != 1 || rd !== 32'h0) begin
        errors++;
        $display("FAIL fault%0d f=%b lat=%0d rd=%h want %b 1 0",
          i, ft, lat, rd, fe[i]);
      end
    end
    do_req(0, 32'h0, 32'h0, 3'b011, 2'b00, rd, ft, lat, bz);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL oor_no_write rd=%h want a5a5a5a5", rd);
    end
    @(negedge clk);
    checks++;
    if (resp_rdata[0] !== 32'hA5A5A5A5 || resp_fault[0] !== 2'b00) begin
      errors++;
      $display("FAIL resp_hold rd=%h f=%b want a5a5a5a5 00",
        resp_rdata[0], resp_fault[0]);
    end
  endtask

  task automatic test_wait();
    logic [31:0] rd; logic [1:0] ft; int lat, bz;
    do_req(1, 32'h8, 32'h01020304, 3'b000, 2'b11, rd, ft, lat, bz);
    checks++;
    if (lat != 5 || bz != 5 || ft !== 2'b00) begin
      errors++;
      $display("FAIL wait_sw lat=%0d busy=%0d f=%b want 5 5 00", lat, bz, ft);
    end
    do_req(1, 32'h8, 32'h0, 3'b011, 2'b00, rd, ft, lat, bz);
    checks++;
    if (rd !== 32'h01020304 || lat != 5) begin
      errors++;
      $display("FAIL wait_lw rd=%h lat=%0d want 01020304 5", rd, lat);
    end
    @(negedge clk);
    checks++;
    if (busy[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle busy=%b rdy=%b want 0 1",
        busy[1], req_ready[1]);
    end
    do_req(1, 32'hA, 32'h0, 3'b110, 2'b00, rd, ft, lat, bz);
    checks++;
    if (rd !== 32'h00000102) begin
      errors++;
      $display("FAIL wait_lhu rd=%h want 00000102", rd);
    end
    do_req(1, 32'h9, 32'h0, 3'b000, 2'b10, rd, ft, lat, bz);
    checks++;
    if (ft !== 2'b00 || lat != 5) begin
      errors++;
      $display("FAIL wait_sh_off1 f=%b lat=%0d want 00 5", ft, lat);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    acc = 0;
    @(negedge clk);
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h8;
    req_load[1]  = 3'b011;
    req_store[1] = 2'b00;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready[1]) acc++;
    end
    req_valid[1] = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (acc != 2) begin
      errors++;
      $display("FAIL back_to_back accepts=%0d want 2", acc);
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd; logic [1:0] ft; int lat, bz, nr;
    do_req(1, 32'h20, 32'h11223344, 3'b000, 2'b11, rd, ft, lat, bz);
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h20;
    req_wdata[1] = 32'hCAFEF00D;
    req_load[1]  = 3'b000;
    req_store[1] = 2'b11;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_busy busy=%b want 1", busy[1]);
    end
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid[1]) nr++;
      @(negedge clk);
    end
    checks++;
    if (nr != 0 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_resp pulses=%0d busy=%b want 0 0", nr, busy[1]);
    end
    do_req(1, 32'h20, 32'h0, 3'b011, 2'b00, rd, ft, lat, bz);
    checks++;
    if (rd !== 32'h11223344) begin
      errors++;
      $display("FAIL rst_wait_data rd=%h want 11223344", rd);
    end
  endtask

  task automatic test_reset_access();
    logic [31:0] rd; logic [1:0] ft; int lat, bz, nr;
    do_req(0, 32'h24, 32'h0BADF00D, 3'b000, 2'b11, rd, ft, lat, bz);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h24;
    req_wdata[0] = 32'h00000077;
    req_load[0]  = 3'b000;
    req_store[0] = 2'b11;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    nr = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid[0]) nr++;
      @(negedge clk);
    end
    do_req(0, 32'h24, 32'h0, 3'b011, 2'b00, rd, ft, lat, bz);
    checks++;
    if (rd !== 32'h0BADF00D || nr != 0) begin
      errors++;
      $display("FAIL rst_access rd=%h pulses=%0d want 0badf00d 0", rd, nr);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d]       = 1'b1;
      req_valid[d] = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_load[d]  = '0;
      req_store[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    test_reset();
    test_word();
    test_subword();
    test_partial();
    test_faults();
    test_wait();
    test_back_to_back();
    test_reset_wait();
    test_reset_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
